// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: collects WIDTH bits from d into a word and
// hands it off through a one-entry output buffer with a valid/ready handshake.
module bit_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         d,
  input  logic                         d_valid,
  input  logic                         clear,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  input  logic                         q_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, word, q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ovf_nxt;
  logic             done;
  logic             hs;

  assign q_valid = (state == FULL);

  // word is the shift register with the current d already shifted in, so the
  // completing bit reaches q on the same edge it is sampled.
  always_comb begin
    if (MSB_FIRST) word = {shreg[WIDTH-2:0], d};
    else           word = {d, shreg[WIDTH-1:1]};

    done = d_valid && !clear && (bit_cnt == CW'(WIDTH - 1));
    hs   = (state == FULL) && q_ready;

    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (clear) begin
      shreg_nxt = '0;
      cnt_nxt   = '0;
    end else if (d_valid) begin
      shreg_nxt = word;
      cnt_nxt   = done ? '0 : bit_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    ovf_nxt   = overflow;
    case (state)
      EMPTY: begin
        if (done) begin
          q_nxt     = word;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (done) begin
          if (hs) q_nxt   = word;
          else    ovf_nxt = 1'b1;
        end else if (hs) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= EMPTY;
      shreg    <= '0;
      bit_cnt  <= '0;
      q        <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= cnt_nxt;
      q        <= q_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: an MSB-first and an LSB-first instance share
// stimulus and are compared every cycle against a queue-based word model.
module tb_bit_deserializer;

  logic       clk = 1'b0;
  logic       reset, d, d_valid, clear, q_ready;
  logic [7:0] q_m, q_l;
  logic       valid_m, valid_l, ovf_m, ovf_l;
  logic [3:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         bits[$];
  logic [7:0] mq_m, mq_l;
  logic       mvalid, movf;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_m), .q_valid(valid_m), .q_ready(q_ready), .bit_cnt(cnt_m),
    .overflow(ovf_m)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_l), .q_valid(valid_l), .q_ready(q_ready), .bit_cnt(cnt_l),
    .overflow(ovf_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic dv,
                            input logic dd, input logic qr);
    logic       hs, done;
    logic [7:0] wm, wl;
    if (!r) begin
      bits.delete();
      mq_m = '0; mq_l = '0; mvalid = 1'b0; movf = 1'b0;
      return;
    end
    hs   = mvalid && qr;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (c) begin
      bits.delete();
    end else if (dv) begin
      bits.push_back(int'(dd));
      if (bits.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          wm[7-i] = bits[i][0];
          wl[i]   = bits[i][0];
        end
        done = 1'b1;
        bits.delete();
      end
    end
    if (done) begin
      if (!mvalid || hs) begin
        mq_m = wm; mq_l = wl; mvalid = 1'b1;
      end else begin
        movf = 1'b1;
      end
    end else if (hs) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("q_msb",     32'(q_m),     32'(mq_m));
    chk("q_lsb",     32'(q_l),     32'(mq_l));
    chk("valid_msb", 32'(valid_m), 32'(mvalid));
    chk("valid_lsb", 32'(valid_l), 32'(mvalid));
    chk("cnt_msb",   32'(cnt_m),   32'(bits.size()));
    chk("cnt_lsb",   32'(cnt_l),   32'(bits.size()));
    chk("ovf_msb",   32'(ovf_m),   32'(movf));
    chk("ovf_lsb",   32'(ovf_l),   32'(movf));
  endtask

  task automatic tick(input logic r, input logic c, input logic dv,
                      input logic dd, input logic qr);
    reset = r; clear = c; d_valid = dv; d = dd; q_ready = qr;
    @(posedge clk);
    model_step(r, c, dv, dd, qr);
    #1;
    compare_all();
  endtask

  // Sends w MSB first; q_ready is qr_last only on the completing bit.
  task automatic send_word(input logic [7:0] w, input logic qr_other, input logic qr_last);
    for (int i = 7; i >= 0; i--)
      tick(1'b1, 1'b0, 1'b1, w[i], (i == 0) ? qr_last : qr_other);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; d_valid = 1'b0; d = 1'b0; q_ready = 1'b0;

    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_q", 32'(q_m), 32'h0);
    chk("reset_valid", 32'(valid_m), 32'h0);

    // MSB-first / LSB-first word
    send_word(8'hB2, 1'b0, 1'b0);
    chk("word_msb_B2", 32'(q_m), 32'hB2);
    chk("word_lsb_4D", 32'(q_l), 32'h4D);
    chk("word_cnt0", 32'(cnt_m), 32'h0);

    // reset pulse between edges has no effect
    reset = 1'b0;
    #3 reset = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("glitch_hold", 32'(q_m), 32'hB2);

    // overflow: second word dropped, flag sticky past handshake
    send_word(8'hFF, 1'b0, 1'b0);
    chk("ovf_hold_q", 32'(q_m), 32'hB2);
    chk("ovf_set", 32'(ovf_m), 32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(ovf_m), 32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_reset", 32'(ovf_m), 32'h0);

    // back-to-back handoff
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    chk("b2b_q", 32'(q_m), 32'h5A);
    chk("b2b_valid", 32'(valid_m), 32'h1);
    chk("b2b_ovf", 32'(ovf_m), 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // clear mid-word, clear beats d_valid
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clear_cnt", 32'(cnt_m), 32'h0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("clear_word", 32'(q_m), 32'hC3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-word
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_mid_cnt", 32'(cnt_m), 32'h0);
    send_word(8'h81, 1'b0, 1'b0);
    chk("rst_mid_word", 32'(q_m), 32'h81);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(0, 79) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
